instruction_decode_unit: RTL
============================

Name: instruction_decode_unit

Overview:
- ID stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch.
- Owns the IF/ID register, the 32x32 register file, the main control decode, load-use and branch hazard detection, and branch/jump resolution.
- Produces stall_stage_ifid, branch, branch_address, jump and jump_address back to fetch, and registers the ID/EX bundle for execute.

Parameters:
- NOP_WORD, 32'h00000000, encoding loaded into IF/ID on reset and on flush.

Ports:
- system_clock  in  1  pipeline clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- if_program_counter  in  32  PC of the word currently presented by fetch
- if_instruction  in  32  instruction word from fetch
- id_ex_mem_read_in  in  1  load currently occupying EX (fed back from ID/EX)
- id_ex_reg_write_in  in  1  EX instruction writes a register
- id_ex_write_reg_in  in  5  EX destination register (already muxed rd/rt)
- ex_mem_reg_write  in  1  MEM-stage instruction writes a register
- ex_mem_mem_read  in  1  MEM-stage instruction is a load
- ex_mem_write_reg  in  5  MEM-stage destination
- ex_mem_alu_result  in  32  MEM-stage ALU result (branch forwarding source)
- wb_reg_write  in  1  register-file write enable
- wb_write_reg  in  5  write address
- wb_write_data  in  32  write data
- stall_stage_ifid  out  1  hold PC and IF/ID
- branch  out  1  taken beq/bne this cycle
- branch_address  out  32  pc+4 + (sext(imm)<<2)
- jump  out  1  j in ID this cycle
- jump_address  out  32  {pc+4[31:28], instr[25:0], 2'b00}
- id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src, id_ex_reg_dst  out  1 each  registered control
- id_ex_alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- id_ex_read_data_1, id_ex_read_data_2, id_ex_immediate, id_ex_pc_plus4  out  32 each  registered datapath
- id_ex_rs, id_ex_rt, id_ex_rd  out  5 each  registered register numbers

Behaviour:
- Reset (sync): IF/ID becomes NOP_WORD with pc 0. All ID/EX outputs become 0. All 32 registers become 0.
- IF/ID register, on posedge:
  - stall holds the current value.
  - Otherwise, (branch|jump) loads NOP_WORD.
  - Otherwise, loads {if_program_counter, if_instruction}.
- Decoded opcodes (constants in the header):
  - R-type 0x00: reg_dst=1, alu_op=10, reg_write=1.
  - lw 0x23: alu_src, mem_read, mem_to_reg, reg_write.
  - sw 0x2B: alu_src, mem_write.
  - beq 0x04 / bne 0x05: alu_op=01, no writes.
  - addi 0x08: alu_src, reg_write.
  - j 0x02: no ID/EX control.
  - Unknown opcodes decode as a bubble (all control 0).
- Register file:
  - Two async read ports and one write port; write on posedge when wb_reg_write and wb_write_reg!=0.
  - $0 always reads 0.
  - Same-cycle write/read to the same nonzero address returns wb_write_data (internal bypass).
- rt counts as a source only for R-type, sw, beq and bne.
- Load-use stall:
  - Condition: id_ex_mem_read_in & id_ex_write_reg_in!=0 & (write_reg==rs | (rt is a source & write_reg==rt)).
- Branch stall (beq/bne in ID), on a source match with a nonzero destination:
  - (a) id_ex_reg_write_in matches → 1 cycle; or
  - (b) ex_mem_mem_read & ex_mem_reg_write match → 1 cycle.
- Branch forwarding: operand taken from ex_mem_alu_result when ex_mem_reg_write & !ex_mem_mem_read & nonzero match; otherwise from the register file (including WB bypass).
- stall_stage_ifid = load-use | branch stall. It is combinational from IF/ID state and inputs.
- During a stall:
  - ID/EX loads a bubble: all control 0, data 0.
  - branch=0 and jump=0, forced even when the ID instruction is a branch or jump.
- branch = !stall & ((beq & a==b) | (bne & a!=b)). jump = !stall & opcode==j.
- Both are combinational, consumed by fetch at the same posedge. Fetch adds one bubble via the flush.
- id_ex_immediate = sign-extended instr[15:0]. id_ex_pc_plus4 = IF/ID pc + 4. Addresses wrap modulo 2^32.
- Reset overrides stall and flush.

Decomposition:
- Shared header datapath/mips_defines.v holds:
  - opcode and funct constants;
  - alu_op encodings;
  - NOP_WORD.
- One sub-module: register_file (32x32, 2R1W, $0 zero, write-through bypass, sync reset).
- Hazard and control decode stay as combinational blocks inside the unit.

Test Plan:
- Reset, then addi $1,$0,5 (0x20010005) at pc 0 → next cycle: id_ex_reg_write=1, alu_src=1, immediate=5, rt=1, pc_plus4=4; all outputs 0 during reset.
- lw $2,0($1) followed by add $3,$2,$1 → stall_stage_ifid=1 for exactly 1 cycle, ID/EX bubble, then add issues with rs=2.
- WB writes $4=0xDEADBEEF in the same cycle ID reads $4 → id_ex_read_data_1=0xDEADBEEF. Writes to $0 → reads 0.
- beq $1,$1,+3 at pc 0x10, no hazards → branch=1, branch_address=0x20, IF/ID holds NOP_WORD on the next cycle.
- beq with ex_mem_write_reg=rs and ex_mem_alu_result equal to rt's value → branch=1 with no stall. With id_ex_reg_write_in matching rs → 1-cycle stall, branch=0 during the stall.
- j 0x0000040 at pc 0x8 → jump=1, jump_address=0x100. Assert reset mid-stall → IF/ID is NOP and all outputs are 0 next cycle.

Source files
------------

// File: rtl/instruction_decode_unit_pkg.sv
// MIPS ID-stage shared constants: opcodes, functs, ALU op encodings, NOP word,
// and the main control decode used by the decode unit.
package instruction_decode_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin c.reg_dst = 1'b1; c.alu_op = ALU_OP_FUNCT; c.reg_write = 1'b1; end
      OP_LW:    begin c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_BEQ,
      OP_BNE:   c.alu_op = ALU_OP_SUB;
      OP_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  // rt is only read as an operand by these formats; for lw/addi it is a destination
  function automatic logic rt_is_source(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
           (opcode == OP_BEQ)   || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/instruction_decode_unit_register_file.sv
// 32x32 register file, two async read ports, one posedge write port.
// $0 reads zero; a same-cycle write to the read address is bypassed to the reader.
module register_file (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_regs [32];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = r_regs[i_raddr1];
    if (i_raddr1 == 5'd0)                      o_rdata1 = '0;
    else if (i_we && (i_waddr == i_raddr1))    o_rdata1 = i_wdata;
  end

  always_comb begin
    o_rdata2 = r_regs[i_raddr2];
    if (i_raddr2 == 5'd0)                      o_rdata2 = '0;
    else if (i_we && (i_waddr == i_raddr2))    o_rdata2 = i_wdata;
  end

endmodule

// File: rtl/instruction_decode_unit.sv
// MIPS ID stage: IF/ID register, register file, control decode, hazard detection,
// branch/jump resolution in ID (combinational to fetch), registered ID/EX bundle.
module instruction_decode_unit
  import instruction_decode_unit_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic [31:0] if_program_counter,
  input  logic [31:0] if_instruction,
  input  logic        id_ex_mem_read_in,
  input  logic        id_ex_reg_write_in,
  input  logic [4:0]  id_ex_write_reg_in,
  input  logic        ex_mem_reg_write,
  input  logic        ex_mem_mem_read,
  input  logic [4:0]  ex_mem_write_reg,
  input  logic [31:0] ex_mem_alu_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  output logic        stall_stage_ifid,
  output logic        branch,
  output logic [31:0] branch_address,
  output logic        jump,
  output logic [31:0] jump_address,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_to_reg,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_alu_src,
  output logic        id_ex_reg_dst,
  output logic [1:0]  id_ex_alu_op,
  output logic [31:0] id_ex_read_data_1,
  output logic [31:0] id_ex_read_data_2,
  output logic [31:0] id_ex_immediate,
  output logic [31:0] id_ex_pc_plus4,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd
);

  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_imm_sext, w_pc_plus4;
  ctrl_t       w_ctrl;
  logic        w_is_beq, w_is_bne, w_is_branch, w_is_j, w_rt_src;
  logic [31:0] w_rf_rd1, w_rf_rd2, w_cmp_a, w_cmp_b;
  logic        w_load_use, w_ex_hit, w_mem_load_hit, w_branch_stall, w_stall;
  logic        w_fwd_a, w_fwd_b;

  assign w_opcode   = r_ifid_instr[31:26];
  assign w_rs       = r_ifid_instr[25:21];
  assign w_rt       = r_ifid_instr[20:16];
  assign w_rd       = r_ifid_instr[15:11];
  assign w_imm_sext = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
  assign w_pc_plus4 = r_ifid_pc + 32'd4;
  assign w_ctrl     = decode_ctrl(w_opcode);
  assign w_is_beq   = (w_opcode == OP_BEQ);
  assign w_is_bne   = (w_opcode == OP_BNE);
  assign w_is_branch = w_is_beq || w_is_bne;
  assign w_is_j     = (w_opcode == OP_J);
  assign w_rt_src   = rt_is_source(w_opcode);

  register_file u_register_file (
    .i_clk    (system_clock),
    .i_rst    (reset),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rf_rd1),
    .o_rdata2 (w_rf_rd2),
    .i_we     (wb_reg_write),
    .i_waddr  (wb_write_reg),
    .i_wdata  (wb_write_data)
  );

  assign w_load_use = id_ex_mem_read_in && (id_ex_write_reg_in != 5'd0) &&
                      ((id_ex_write_reg_in == w_rs) ||
                       (w_rt_src && (id_ex_write_reg_in == w_rt)));

  // Branches compare in ID, so any producer still in EX, or a load in MEM, is too late
  assign w_ex_hit = id_ex_reg_write_in && (id_ex_write_reg_in != 5'd0) &&
                    ((id_ex_write_reg_in == w_rs) || (id_ex_write_reg_in == w_rt));
  assign w_mem_load_hit = ex_mem_mem_read && ex_mem_reg_write && (ex_mem_write_reg != 5'd0) &&
                          ((ex_mem_write_reg == w_rs) || (ex_mem_write_reg == w_rt));
  assign w_branch_stall = w_is_branch && (w_ex_hit || w_mem_load_hit);
  assign w_stall        = w_load_use || w_branch_stall;

  assign w_fwd_a = ex_mem_reg_write && !ex_mem_mem_read && (ex_mem_write_reg != 5'd0) &&
                   (ex_mem_write_reg == w_rs);
  assign w_fwd_b = ex_mem_reg_write && !ex_mem_mem_read && (ex_mem_write_reg != 5'd0) &&
                   (ex_mem_write_reg == w_rt);
  assign w_cmp_a = w_fwd_a ? ex_mem_alu_result : w_rf_rd1;
  assign w_cmp_b = w_fwd_b ? ex_mem_alu_result : w_rf_rd2;

  assign stall_stage_ifid = w_stall;
  assign branch = !w_stall && ((w_is_beq && (w_cmp_a == w_cmp_b)) ||
                               (w_is_bne && (w_cmp_a != w_cmp_b)));
  assign jump   = !w_stall && w_is_j;
  assign branch_address = w_pc_plus4 + {w_imm_sext[29:0], 2'b00};
  assign jump_address   = {w_pc_plus4[31:28], r_ifid_instr[25:0], 2'b00};

  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_WORD;
    end else if (w_stall) begin
      r_ifid_pc    <= r_ifid_pc;
      r_ifid_instr <= r_ifid_instr;
    end else if (branch || jump) begin
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_WORD;
    end else begin
      r_ifid_pc    <= if_program_counter;
      r_ifid_instr <= if_instruction;
    end
  end

  // A stall issues a full bubble into EX while the stalled instruction waits in ID
  always_ff @(posedge system_clock) begin
    if (reset || w_stall) begin
      id_ex_reg_write   <= 1'b0;
      id_ex_mem_to_reg  <= 1'b0;
      id_ex_mem_read    <= 1'b0;
      id_ex_mem_write   <= 1'b0;
      id_ex_alu_src     <= 1'b0;
      id_ex_reg_dst     <= 1'b0;
      id_ex_alu_op      <= '0;
      id_ex_read_data_1 <= '0;
      id_ex_read_data_2 <= '0;
      id_ex_immediate   <= '0;
      id_ex_pc_plus4    <= '0;
      id_ex_rs          <= '0;
      id_ex_rt          <= '0;
      id_ex_rd          <= '0;
    end else begin
      id_ex_reg_write   <= w_ctrl.reg_write;
      id_ex_mem_to_reg  <= w_ctrl.mem_to_reg;
      id_ex_mem_read    <= w_ctrl.mem_read;
      id_ex_mem_write   <= w_ctrl.mem_write;
      id_ex_alu_src     <= w_ctrl.alu_src;
      id_ex_reg_dst     <= w_ctrl.reg_dst;
      id_ex_alu_op      <= w_ctrl.alu_op;
      id_ex_read_data_1 <= w_rf_rd1;
      id_ex_read_data_2 <= w_rf_rd2;
      id_ex_immediate   <= w_imm_sext;
      id_ex_pc_plus4    <= w_pc_plus4;
      id_ex_rs          <= w_rs;
      id_ex_rt          <= w_rt;
      id_ex_rd          <= w_rd;
    end
  end

endmodule
